// File: rtl/ysyx_041461_pipe_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline register: reset PC and occupancy helpers.
package ysyx_041461_pipe_skid_reg_pkg;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/ysyx_041461_pipe_slot.sv
// One storage slot: valid flop plus DATA_W data flop with load/clear and async reset.
module ysyx_041461_pipe_slot #(
  parameter int unsigned          DATA_W  = 64,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load wins over clear; data only changes on load so it holds across flushes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ysyx_041461_pipe_skid_reg.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer and flush.
module ysyx_041461_pipe_skid_reg
  import ysyx_041461_pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit                SKID    = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_occupancy
);

  logic              w_main_valid;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [DATA_W-1:0] w_main_din;
  logic              w_acc_in;
  logic              w_acc_out;
  logic              w_main_load;
  logic              w_main_clear;

  // Skid mode keeps in_ready purely flop-derived; 1-slot mode passes out_ready through.
  assign o_in_ready = SKID ? ~w_skid_valid : (~w_main_valid | i_out_ready);

  assign w_acc_in  = i_in_valid & o_in_ready;
  assign w_acc_out = w_main_valid & i_out_ready;

  // When the skid slot is full in_ready is low, so the refill comes from skid only.
  assign w_main_load  = ~i_flush & ((w_skid_valid & w_acc_out) |
                                    (w_acc_in & (~w_main_valid | w_acc_out)));
  assign w_main_clear = i_flush | (w_acc_out & ~w_acc_in & ~w_skid_valid);
  assign w_main_din   = w_skid_valid ? w_skid_data : i_in_data;

  ysyx_041461_pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (o_out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic w_skid_load;
      logic w_skid_clear;

      assign w_skid_load  = ~i_flush & w_acc_in & w_main_valid & ~w_acc_out;
      assign w_skid_clear = i_flush | w_acc_out;

      ysyx_041461_pipe_slot #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
      ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (i_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = RST_VAL;
    end
  endgenerate

  assign o_out_valid = w_main_valid;
  assign o_occupancy = occ_count(w_main_valid, w_skid_valid);

endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// Bench for the elastic pipeline register: dut0 in skid mode, dut1 in 1-slot mode.
module tb_ysyx_041461_pipe_skid_reg;
  import ysyx_041461_pipe_skid_reg_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [63:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [63:0] out_data  [2];
  logic [1:0]  occ       [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb0[$];
  logic [63:0] sb1[$];
  logic [63:0] last_out  [2];
  int          delivered [2];
  int          next_id   [2];

  ysyx_041461_pipe_skid_reg #(.DATA_W(64), .RST_VAL(RESET_PC), .SKID(1'b1)) u_dut0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush[0]),
    .i_in_valid  (in_valid[0]),
    .o_in_ready  (in_ready[0]),
    .i_in_data   (in_data[0]),
    .o_out_valid (out_valid[0]),
    .i_out_ready (out_ready[0]),
    .o_out_data  (out_data[0]),
    .o_occupancy (occ[0])
  );

  ysyx_041461_pipe_skid_reg #(.DATA_W(64), .RST_VAL(RESET_PC), .SKID(1'b0)) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush[1]),
    .i_in_valid  (in_valid[1]),
    .o_in_ready  (in_ready[1]),
    .i_in_data   (in_data[1]),
    .o_out_valid (out_valid[1]),
    .i_out_ready (out_ready[1]),
    .o_out_data  (out_data[1]),
    .o_occupancy (occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [63:0] sb_front(input int d);
    if (d == 0) return sb0[0];
    return sb1[0];
  endfunction

  task automatic sb_clear(input int d);
    if (d == 0) sb0.delete();
    else sb1.delete();
  endtask

  task automatic sb_push(input int d, input logic [63:0] v);
    if (d == 0) sb0.push_back(v);
    else sb1.push_back(v);
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(sb0.pop_front());
    else void'(sb1.pop_front());
  endtask

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic expect_out(input int d, input logic ir, input logic ov, input logic [1:0] oc,
                            input logic [63:0] od);
    check("tbl_in_ready", d, 64'(in_ready[d]), 64'(ir));
    check("tbl_out_valid", d, 64'(out_valid[d]), 64'(ov));
    check("tbl_occupancy", d, 64'(occ[d]), 64'(oc));
    check("tbl_out_data", d, out_data[d], od);
  endtask

  // Compare both DUTs against the FIFO model, then advance one clock and update the model.
  task automatic step();
    bit   ai [2];
    bit   ao [2];
    int   sz;
    logic exp_ir;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz = sb_size(d);
      if (rst) exp_ir = 1'b1;
      else if (d == 0) exp_ir = (sz < 2);
      else exp_ir = (sz == 0) || out_ready[d];
      check("in_ready", d, 64'(in_ready[d]), 64'(exp_ir));
      check("out_valid", d, 64'(out_valid[d]), 64'(sz > 0));
      check("occupancy", d, 64'(occ[d]), 64'(sz));
      check("out_data", d, out_data[d], last_out[d]);
      ai[d] = in_valid[d] && exp_ir && !rst;
      ao[d] = (sz > 0) && out_ready[d] && !rst;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sb_clear(d);
        last_out[d] = RESET_PC;
      end else if (flush[d]) begin
        sb_clear(d);
      end else begin
        if (ao[d]) begin
          sb_pop(d);
          delivered[d]++;
        end
        if (ai[d]) begin
          sb_push(d, in_data[d]);
          next_id[d]++;
        end
      end
      if (sb_size(d) > 0) last_out[d] = sb_front(d);
    end
    #1;
  endtask

  task automatic drive(input int d, input logic fl, input logic iv, input logic [63:0] din,
                       input logic ordy);
    flush[d]     = fl;
    in_valid[d]  = iv;
    in_data[d]   = din;
    out_ready[d] = ordy;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [63:0] din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic [63:0] e_od;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [63:0] din,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [1:0] e_occ, input logic [63:0] e_od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_od = e_od;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    int cyc;

    // Table rows: inputs for the cycle and the outputs expected before that cycle's edge.
    tbl[0]  = mk(0, 1, 64'h11, 1, 1, 0, 0, RESET_PC);
    tbl[1]  = mk(0, 1, 64'h22, 1, 1, 1, 1, 64'h11);
    tbl[2]  = mk(0, 1, 64'h33, 1, 1, 1, 1, 64'h22);
    tbl[3]  = mk(0, 0, 64'h0,  1, 1, 1, 1, 64'h33);
    tbl[4]  = mk(0, 1, 64'hA,  0, 1, 0, 0, 64'h33);
    tbl[5]  = mk(0, 1, 64'hB,  0, 1, 1, 1, 64'hA);
    tbl[6]  = mk(0, 1, 64'hC,  0, 0, 1, 2, 64'hA);
    tbl[7]  = mk(0, 1, 64'hC,  0, 0, 1, 2, 64'hA);
    tbl[8]  = mk(0, 1, 64'hC,  1, 0, 1, 2, 64'hA);
    tbl[9]  = mk(0, 1, 64'hC,  1, 1, 1, 1, 64'hB);
    tbl[10] = mk(0, 0, 64'h0,  1, 1, 1, 1, 64'hC);
    tbl[11] = mk(0, 0, 64'h0,  0, 1, 0, 0, 64'hC);
    tbl[12] = mk(0, 1, 64'hE,  0, 1, 0, 0, 64'hC);
    tbl[13] = mk(0, 1, 64'hF,  0, 1, 1, 1, 64'hE);
    tbl[14] = mk(1, 1, 64'hD,  0, 0, 1, 2, 64'hE);
    tbl[15] = mk(1, 1, 64'hD,  0, 1, 0, 0, 64'hE);
    tbl[16] = mk(0, 0, 64'h0,  1, 1, 0, 0, 64'hE);

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 0, 64'h0, 0);
      last_out[d]  = RESET_PC;
      delivered[d] = 0;
      next_id[d]   = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      drive(0, tbl[i].fl, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      drive(1, 0, 0, 64'h0, 1);
      #1;
      expect_out(0, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_occ, tbl[i].e_od);
      step();
    end

    // Reset in the middle of a stream with both slots of dut0 full.
    drive(0, 0, 1, 64'h71, 0);
    drive(1, 0, 1, 64'h81, 0);
    step();
    drive(0, 0, 1, 64'h72, 0);
    step();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_out_valid", d, 64'(out_valid[d]), 64'h0);
      check("rst_out_data", d, out_data[d], RESET_PC);
      check("rst_occupancy", d, 64'(occ[d]), 64'h0);
      check("rst_in_ready", d, 64'(in_ready[d]), 64'h1);
      sb_clear(d);
      last_out[d] = RESET_PC;
    end
    step();
    rst = 1'b0;
    drive(0, 0, 0, 64'h0, 1);
    drive(1, 0, 0, 64'h0, 1);
    step();

    // 1-slot mode: in_ready follows out_ready combinationally while main is full.
    drive(0, 0, 0, 64'h0, 1);
    drive(1, 0, 1, 64'h55, 0);
    #1;
    expect_out(1, 1, 0, 0, RESET_PC);
    step();
    drive(1, 0, 1, 64'h66, 0);
    #1;
    expect_out(1, 0, 1, 1, 64'h55);
    step();
    out_ready[1] = 1'b1;
    #1;
    expect_out(1, 1, 1, 1, 64'h55);
    step();
    drive(1, 0, 0, 64'h0, 0);
    #1;
    expect_out(1, 0, 1, 1, 64'h66);
    step();

    // Random valid/ready on both DUTs concurrently, with occasional flushes.
    for (int d = 0; d < 2; d++) delivered[d] = 0;
    cyc = 0;
    while ((delivered[0] < 10000 || delivered[1] < 10000) && cyc < 60000) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(199) == 0), ($urandom_range(9) < 8),
              {32'(d + 1), 32'(next_id[d])}, ($urandom_range(9) < 7));
      end
      step();
      cyc++;
    end
    n_checks++;
    if (cyc >= 60000) begin
      n_fail++;
      $display("FAIL random_budget: delivered %0d/%0d required 10000 each",
               delivered[0], delivered[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
